// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg
// Shared definitions for the multiplier arbiter slice: FSM state
// encoding, default operand width / requester count, and the width of
// the optional watchdog counter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  // Watchdog counter width, wide enough for the default limit of 1023.
  localparam int TO_CNT_W = 10;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotating-priority encoder. Searches req starting at
// ptr, then ptr+1, ... wrapping modulo N, and returns the first set
// index.
// Ports:
//   req   in   N      request vector
//   ptr   in   IW     search start position (0..N-1)
//   grant out  IW     index of the first set bit at or after ptr
//   any   out  1      at least one request is set
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  // rot[k] is the request at position (ptr + k) mod N.
  logic [N-1:0]  rot;
  logic [IW-1:0] rot_idx [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [SW-1:0] sum;
    assign sum         = {1'b0, ptr} + SW'(gi);
    assign rot_idx[gi] = (sum >= SW'(N)) ? IW'(sum - SW'(N)) : sum[IW-1:0];
    assign rot[gi]     = req[rot_idx[gi]];
  end

  // Walk from the far end so the lowest rotated offset wins.
  always_comb begin
    any   = 1'b0;
    grant = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any   = 1'b1;
        grant = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter
// Shares one repeated-addition multiplier among N requesters with
// round-robin arbitration. Operands of the winner are latched and
// presented to the multiplier, start is pulsed for one cycle, and the
// product is returned with a one-cycle one-hot ack. Requests with a
// zero operand are answered directly without starting the multiplier.
// Optional watchdog: define MUL_ARB_TIMEOUT_EN to bound the wait for
// mul_done to TIMEOUT_CYCLES; the job then completes with err=1.
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous, active-low reset
//   req        in   N     request levels (sampled only in IDLE)
//   a_in/b_in  in   N*W   operands, requester i at [i*W +: W]
//   ack        out  N     one-hot completion pulse
//   result     out  2W    product, valid while ack != 0
//   err        out  1     watchdog expired (valid with ack)
//   busy       out  1     FSM not in IDLE
//   mul_start  out  1     multiplier start pulse
//   mul_a/b    out  W     registered operands to the multiplier
//   mul_done   in   1     multiplier finished
//   mul_result in   2W    multiplier product, valid with mul_done
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N              = DEF_N,
  parameter int W              = DEF_W,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   ack,
  output logic [2*W-1:0] result,
  output logic           err,
  output logic           busy,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_result
);

  localparam int IW = $clog2(N);

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [W-1:0]    mul_a_reg, mul_a_next;
  logic [W-1:0]    mul_b_reg, mul_b_next;
  logic [2*W-1:0]  result_reg, result_next;
  logic            err_reg, err_next;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [W-1:0]    pick_a, pick_b;
  logic            timeout;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (pick_idx),
    .any   (pick_any)
  );

  assign pick_a = a_in[pick_idx*W +: W];
  assign pick_b = b_in[pick_idx*W +: W];

  // A limit outside the counter range cannot be reached; this block only
  // exists when that is the case, making the misconfiguration visible.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TO_CNT_W) - 1) begin : g_timeout_out_of_range
  end

`ifdef MUL_ARB_TIMEOUT_EN
  // Counter is 0 in the first WAIT cycle; the job times out at the end
  // of the TIMEOUT_CYCLES-th WAIT cycle unless mul_done arrives then.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TO_CNT_W-1:0] cnt_reg, cnt_next;
  assign timeout = (cnt_reg == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    grant_next  = grant_reg;
    mul_a_next  = mul_a_reg;
    mul_b_next  = mul_b_reg;
    result_next = result_reg;
    err_next    = err_reg;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_next    = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next = pick_idx;
          mul_a_next = pick_a;
          mul_b_next = pick_b;
          ptr_next   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
          err_next   = 1'b0;
          if (pick_a == '0 || pick_b == '0) begin
            result_next = '0;
            state_next  = RESP;
          end else begin
            state_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
        state_next = WAIT;
      end
      WAIT: begin
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_next = cnt_reg + TO_CNT_W'(1);
`endif
        // A done coinciding with the timeout takes priority.
        if (mul_done) begin
          result_next = mul_result;
          state_next  = RESP;
        end else if (timeout) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      grant_reg  <= '0;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      grant_reg  <= grant_next;
      mul_a_reg  <= mul_a_next;
      mul_b_reg  <= mul_b_next;
      result_reg <= result_next;
      err_reg    <= err_next;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  always_comb begin
    ack = '0;
    if (state_reg == RESP) begin
      ack[grant_reg] = 1'b1;
    end
  end

  assign result    = result_reg;
  assign err       = err_reg;
  assign busy      = (state_reg != IDLE);
  assign mul_start = (state_reg == ISSUE);
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter
// Directed bench for mul_arbiter with a behavioural multiplier that
// raises mul_done a programmable number of cycles after mul_start.
// Define MUL_ARB_TIMEOUT_EN to include the watchdog steps (limit 20).
module tb_mul_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   ack;
  logic [2*W-1:0] result;
  logic           err;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_done = 1'b0;
  logic [2*W-1:0] mul_result = '0;

  int vectors = 0;
  int miscompares = 0;

  mul_arbiter #(.N(N), .W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .ack        (ack),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  always #5 clk = ~clk;

  // Multiplier model: done_delay=D raises mul_done so it is sampled at
  // the end of the D-th cycle after the start cycle; D=0 never finishes.
  int             done_delay = 6;
  int             mdl_cnt = 0;
  bit             mdl_active = 1'b0;
  logic [2*W-1:0] mdl_prod = '0;
  int             start_cnt = 0;

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (!rst) begin
      mdl_active = 1'b0;
      mdl_cnt    = 0;
    end else if (mul_start) begin
      mdl_active = 1'b1;
      mdl_cnt    = 0;
      mdl_prod   = (2*W)'(mul_a) * (2*W)'(mul_b);
      start_cnt++;
    end else if (mdl_active) begin
      mdl_cnt++;
      if (done_delay != 0 && mdl_cnt == done_delay) begin
        mul_done   = 1'b1;
        mul_result = mdl_prod;
        mdl_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until ack appears or the budget runs out; cycles counts ticks.
  task automatic wait_ack(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (ack == '0 && cycles < budget) begin
      tick();
      cycles++;
    end
    check({tag, "_ack_seen"}, 32'(ack != '0), 1);
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
  endtask

  initial begin
    int cyc;
    int s0;
    logic [N-1:0] ack_or;

    // ---- reset state ----
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_result", 32'(result), 0);
    check("rst_err", 32'(err), 0);
    check("rst_start", 32'(mul_start), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    rst = 1'b1;
    tick();

    // ---- 1: single request 3*5, done 6 cycles after start ----
    s0 = start_cnt;
    done_delay = 6;
    set_ops(0, 8'd3, 8'd5);
    req = 4'b0001;
    tick();
    check("t1_start", 32'(mul_start), 1);
    check("t1_mul_a", 32'(mul_a), 3);
    check("t1_mul_b", 32'(mul_b), 5);
    check("t1_busy", 32'(busy), 1);
    wait_ack("t1", 100, cyc);
    check("t1_latency", 32'(cyc), 7);
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_result", 32'(result), 15);
    check("t1_err", 32'(err), 0);
    check("t1_starts", 32'(start_cnt - s0), 1);
    req = 4'b0000;
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_ack", 32'(ack), 0);
    check("t1_result_hold", 32'(result), 15);

    // ---- 4: reset during WAIT aborts job and clears ptr ----
    set_ops(0, 8'd9, 8'd9);
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("t4_in_wait", 32'(busy), 1);
    rst = 1'b0;
    tick();
    check("t4_busy", 32'(busy), 0);
    check("t4_ack", 32'(ack), 0);
    check("t4_result", 32'(result), 0);
    check("t4_start", 32'(mul_start), 0);
    check("t4_mul_a", 32'(mul_a), 0);
    check("t4_mul_b", 32'(mul_b), 0);
    rst = 1'b1;
    req = 4'b0000;
    ack_or = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ack_or = ack_or | ack;
    end
    check("t4_no_ack", 32'(ack_or), 0);
    // ptr back at 0: requester 0 wins over requester 3.
    set_ops(0, 8'd1, 8'd7);
    set_ops(3, 8'd2, 8'd2);
    req = 4'b1001;
    tick();
    check("t4_ptr_grant", 32'(mul_a), 1);
    wait_ack("t4a", 100, cyc);
    check("t4a_ack", 32'(ack), 32'h1);
    check("t4a_result", 32'(result), 7);
    req = 4'b1000;
    tick();
    wait_ack("t4b", 100, cyc);
    check("t4b_ack", 32'(ack), 32'h8);
    check("t4b_result", 32'(result), 4);
    req = 4'b0000;
    tick();

    // ---- 2: round robin with all four requesting ----
    done_delay = 2;
    for (int i = 0; i < N; i++) begin
      set_ops(i, W'(i + 1), W'(10 + i));
    end
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      int idx;
      idx = j % N;
      wait_ack("t2", 100, cyc);
      check("t2_ack", 32'(ack), 32'(1 << idx));
      check("t2_onehot", 32'($countones(ack)), 1);
      check("t2_result", 32'(result), 32'((idx + 1) * (10 + idx)));
      if (j < 4) begin
        req[idx] = 1'b0;
        tick();
        req[idx] = 1'b1;
      end else begin
        req = 4'b0000;
        tick();
      end
    end

    // ---- 3: zero operand shortcut ----
    s0 = start_cnt;
    set_ops(2, 8'd0, 8'd200);
    req = 4'b0100;
    tick();
    check("t3_ack", 32'(ack), 32'h4);
    check("t3_result", 32'(result), 0);
    check("t3_start", 32'(mul_start), 0);
    req = 4'b0000;
    tick();
    check("t3_busy", 32'(busy), 0);
    check("t3_starts", 32'(start_cnt - s0), 0);

    // ---- 5: max operands ----
    done_delay = 3;
    set_ops(1, 8'd255, 8'd255);
    req = 4'b0010;
    wait_ack("t5", 100, cyc);
    check("t5_ack", 32'(ack), 32'h2);
    check("t5_result", 32'(result), 65025);
    req = 4'b0000;
    tick();

`ifdef MUL_ARB_TIMEOUT_EN
    // ---- 6: watchdog ----
    done_delay = 0;
    set_ops(2, 8'd5, 8'd6);
    req = 4'b0100;
    tick();
    wait_ack("t6a", 100, cyc);
    check("t6a_latency", 32'(cyc), 21);
    check("t6a_ack", 32'(ack), 32'h4);
    check("t6a_err", 32'(err), 1);
    check("t6a_result", 32'(result), 0);
    req = 4'b0000;
    tick();
    done_delay = 20;
    set_ops(3, 8'd3, 8'd4);
    req = 4'b1000;
    tick();
    wait_ack("t6b", 100, cyc);
    check("t6b_latency", 32'(cyc), 21);
    check("t6b_ack", 32'(ack), 32'h8);
    check("t6b_err", 32'(err), 0);
    check("t6b_result", 32'(result), 12);
    req = 4'b0000;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one repeated-addition multiplier datapath (CU plus R1–R4) among N requesters.
- Round-robin arbitration; winner's operands latched and driven to the multiplier; start pulsed; done awaited; result returned with a one-cycle ack.
- Sits between client blocks and the multiplier's S/done interface.
- Zero-operand requests are answered directly, without occupying the multiplier.

Parameters:
N, 4, number of requesters (2..8)
W, 8, operand width; product width is 2W
TIMEOUT_CYCLES, 1023, watchdog limit; used only with MUL_ARB_TIMEOUT_EN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
req  input  N  per-requester request level
a_in  input  N*W  operand A, requester i at [i*W +: W]
b_in  input  N*W  operand B, same packing
ack  output  N  one-hot, one-cycle completion pulse
result  output  2W  product, valid while ack != 0
err  output  1  timeout flag, valid with ack (tied 0 without the feature)
busy  output  1  high in every state except IDLE
mul_start  output  1  one-cycle start (drives multiplier S)
mul_a  output  W  registered operand A to multiplier
mul_b  output  W  registered operand B to multiplier
mul_done  input  1  multiplier finished (its return to init)
mul_result  input  2W  multiplier product, valid with mul_done

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, ptr=0, ack=0, result=0, err=0, busy=0, mul_start=0, mul_a=mul_b=0, grant reg=0.
- Reset mid-operation aborts the job; no ack issued. The multiplier shares rst.
- Requester protocol:
  - Hold req=1 and operands stable until ack.
  - Drop req in the cycle after ack.
  - req is sampled only in IDLE; req changes in other states are ignored.
- Arbitration (IDLE, any req set):
  - Winner = first set bit searching ptr, ptr+1, ..., wrapping modulo N.
  - Latch grant index and operands into mul_a/mul_b.
  - ptr <= winner+1 (mod N) at grant time.
- States:
  - IDLE:
    - No req: stay in IDLE.
    - Winner with a==0 or b==0: go to RESP with result=0 (zero shortcut).
    - Otherwise: go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; go to WAIT.
  - WAIT:
    - mul_done==1: capture mul_result into result, go to RESP.
    - Otherwise: stay in WAIT.
    - mul_done during ISSUE is ignored.
  - RESP: ack[grant]=1 for one cycle, result/err held valid; go to IDLE.
- Latency, req high in IDLE at cycle t:
  - Normal path: ISSUE at t+1, WAIT from t+2, ack one cycle after mul_done is sampled.
  - Zero path: ack at t+1.
- Back-to-back: ack in cycle k; next grant decided in IDLE at k+1. Minimum 2 cycles between jobs.
- result holds its last value outside RESP. ack is never asserted on more than one bit.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Enabled:
  - A 10-bit (clog2) cycle counter clears on ISSUE and increments in WAIT.
  - When the counter reaches TIMEOUT_CYCLES without mul_done: go to RESP with err=1, result=0; ack still pulses for the granted requester.
  - mul_done arriving in the same cycle as the timeout wins: err=0.
- Disabled: no counter; err tied 0; WAIT is unbounded.

Decomposition:
- Package mul_arb_pkg:
  - State localparams IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11.
  - Default W and N.
  - Timeout counter width constant.
- Sub-module rr_pick (N):
  - Inputs: req, ptr. Outputs: grant index, any.
  - Purely combinational rotate-priority-encode.
- The FSM, latches and timeout stay in mul_arbiter.

Test Plan:
1. Single request: req=4'b0001, a=3, b=5; multiplier model gives done 6 cycles after start -> one mul_start pulse, mul_a=3, mul_b=5, ack=4'b0001 with result=15 one cycle after done, busy low afterwards.
2. Round-robin: req=4'b1111 held, each requester re-asserting after ack -> grant order 0,1,2,3,0; no requester served twice before the others.
3. Zero shortcut: req[2]=1, a=0, b=200 -> ack[2] at t+1, result=0, mul_start never asserted.
4. Reset mid-WAIT: drop rst for one cycle while waiting -> all outputs 0, state IDLE, no ack, ptr=0; next request (req[3], a=2, b=2) completes with result=4.
5. Max operands: a=255, b=255 -> result=65025 (16'hFE01), no truncation.
6. Timeout (MUL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20, multiplier never returns done) -> ack pulses for the granted requester with err=1, result=0; a repeat run with done exactly at cycle 20 gives err=0.
